fifo_rd_ctrl: RTL and testbench
===============================

Name: fifo_rd_ctrl

Overview:
Read-side drain controller for the async FIFO. Runs in the read clock domain and watches REMPTY. Pops one word at a time and presents it to a serial consumer (e.g. UART TX) through a valid-pulse/busy handshake. Adds a programmable inter-word gap and a busy-acknowledge timeout.

Parameters:
WIDTH, 8, data word width; must match the FIFO.
GAP, 2, minimum idle cycles after a transfer completes before the next pop; 0 means return directly to IDLE.
TIMEOUT, 255, cycles to wait for the consumer to raise CONS_BUSY after OUT_VALID; 0 disables the timeout (waits forever).

Ports:
R_CLK  input  1  read-domain clock; all state changes on the rising edge.
R_RST  input  1  asynchronous active-low reset.
EN  input  1  controller enable; sampled only in IDLE.
REMPTY  input  1  FIFO empty flag.
RD_DATA  input  WIDTH  FIFO read data; combinational at the current read address; stable until a pop.
CONS_BUSY  input  1  consumer busy.
R_INC  output  1  FIFO pop strobe; registered.
OUT_DATA  output  WIDTH  word handed to the consumer; registered; held until the next pop.
OUT_VALID  output  1  one-cycle pulse; OUT_DATA is new.
TO_ERR  output  1  sticky timeout flag.

Behaviour:
- Reset (R_RST=0, asynchronous): state=IDLE; R_INC=0, OUT_VALID=0, OUT_DATA=0, TO_ERR=0; gap and timeout counters=0.
- Reset mid-transfer aborts immediately. A word popped before reset may be lost; this is accepted.
- FSM states: IDLE, POP, WAIT_BUSY, WAIT_DONE, GAP_WAIT.
- IDLE:
  - If EN && !REMPTY && !CONS_BUSY at an edge: OUT_DATA<=RD_DATA, R_INC<=1, OUT_VALID<=1, go to POP.
  - Otherwise stay in IDLE.
- POP: lasts exactly 1 cycle, with R_INC=1 and OUT_VALID=1. At the edge: R_INC<=0, OUT_VALID<=0, timeout counter<=0, go to WAIT_BUSY.
- Latency: first pop lands 1 edge after the IDLE condition is sampled true. R_INC is never high for more than 1 consecutive cycle.
- WAIT_BUSY:
  - If CONS_BUSY=1, go to WAIT_DONE.
  - Else, if TIMEOUT!=0 and counter==TIMEOUT-1: TO_ERR<=1, go to GAP_WAIT.
  - Else, counter increments.
  - Timeout counter width is $clog2(TIMEOUT+1), with a minimum of 1.
- WAIT_DONE: when CONS_BUSY=0, go to GAP_WAIT (or IDLE if GAP=0). No pop is ever issued while CONS_BUSY=1.
- GAP_WAIT: counts GAP cycles, then goes to IDLE. Gap counter width is $clog2(GAP+1), with a minimum of 1.
- EN deasserted outside IDLE: the current transfer completes normally, and no further pop occurs.
- TO_ERR: set as above. Cleared only when EN=0 is sampled in IDLE, or by reset. A simultaneous set and clear cannot occur, because they are evaluated in different states.
- REMPTY rising in a non-IDLE state is ignored; it is sampled only in IDLE.
- Since R_INC is asserted only when REMPTY=0, no pop is ever issued to an empty FIFO.

Optional Feature:
- Macro RD_CTRL_XFER_CNT_EN.
- Defined: adds output port XFER_CNT (16 bits).
  - Reset value 0.
  - Increments by 1 on every POP cycle.
  - Wraps 16'hFFFF -> 16'h0000.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert R_RST=0 at any state -> R_INC=0, OUT_VALID=0, OUT_DATA=8'h00, TO_ERR=0 in the same cycle; first pop occurs only after release, with EN=1 and REMPTY=0.
- Single word: EN=1, REMPTY=0, RD_DATA=8'hA5, CONS_BUSY=0. Consumer raises busy 1 cycle after OUT_VALID for 3 cycles. Required:
  - Next edge gives OUT_DATA=8'hA5 with R_INC=OUT_VALID=1 for exactly 1 cycle.
  - After busy falls, 2 GAP cycles elapse, then IDLE.
  - Exactly one R_INC pulse in total.
- Burst: FIFO holds 8'h11, 8'h22, 8'h33; consumer busy 4 cycles per word -> OUT_DATA sequence 11, 22, 33 in order; exactly 3 R_INC pulses; none while CONS_BUSY=1; at least 2 idle cycles between busy-fall and the next R_INC.
- Timeout: TIMEOUT=4, consumer never raises busy, 2 words queued. Required:
  - TO_ERR rises 4 cycles after entering WAIT_BUSY.
  - The second word is still popped after GAP.
  - TO_ERR stays 1 until EN=0 is sampled in IDLE, then clears to 0.
- Enable drop: EN=0 during WAIT_DONE with REMPTY=0 -> the current transfer finishes and no further R_INC occurs. Re-assert EN=1 -> a pop occurs 1 edge after IDLE samples the condition true.
- Counter (RD_CTRL_XFER_CNT_EN defined): preload via 65535 pops or force XFER_CNT to 16'hFFFF, then do 1 more pop -> XFER_CNT=16'h0000.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
// Read-domain drain controller: pops one FIFO word at a time into a valid/busy consumer,
// with an inter-word gap and a busy-acknowledge timeout. Define RD_CTRL_XFER_CNT_EN for XFER_CNT.
module fifo_rd_ctrl #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned GAP     = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             R_CLK,
  input  logic             R_RST,
  input  logic             EN,
  input  logic             REMPTY,
  input  logic [WIDTH-1:0] RD_DATA,
  input  logic             CONS_BUSY,
  output logic             R_INC,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_VALID,
  output logic             TO_ERR
`ifdef RD_CTRL_XFER_CNT_EN
  ,
  output logic [15:0]      XFER_CNT
`endif
);

  localparam int unsigned TO_W  = (TIMEOUT == 32'd0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned GAP_W = (GAP == 32'd0) ? 1 : $clog2(GAP + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    POP       = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GAP_WAIT  = 3'd4
  } state_t;

  state_t             state, state_n;
  logic [TO_W-1:0]    to_cnt, to_cnt_n;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
  logic               r_inc_n, out_valid_n, to_err_n;
  logic [WIDTH-1:0]   out_data_n;

  // Next-state and next-output decode
  always_comb begin
    state_n     = state;
    to_cnt_n    = to_cnt;
    gap_cnt_n   = gap_cnt;
    r_inc_n     = 1'b0;
    out_valid_n = 1'b0;
    out_data_n  = OUT_DATA;
    to_err_n    = TO_ERR;

    case (state)
      IDLE: begin
        if (!EN) begin
          to_err_n = 1'b0;
        end
        if (EN && !REMPTY && !CONS_BUSY) begin
          out_data_n  = RD_DATA;
          r_inc_n     = 1'b1;
          out_valid_n = 1'b1;
          state_n     = POP;
        end
      end
      POP: begin
        to_cnt_n = '0;
        state_n  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (CONS_BUSY) begin
          state_n = WAIT_DONE;
        end else if ((TIMEOUT != 32'd0) && (to_cnt == TO_LAST)) begin
          to_err_n  = 1'b1;
          gap_cnt_n = '0;
          state_n   = (GAP == 32'd0) ? IDLE : GAP_WAIT;
        end else begin
          to_cnt_n = to_cnt + TO_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!CONS_BUSY) begin
          gap_cnt_n = '0;
          state_n   = (GAP == 32'd0) ? IDLE : GAP_WAIT;
        end
      end
      GAP_WAIT: begin
        if (gap_cnt == GAP_LAST) begin
          state_n = IDLE;
        end else begin
          gap_cnt_n = gap_cnt + GAP_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      state     <= IDLE;
      to_cnt    <= '0;
      gap_cnt   <= '0;
      R_INC     <= 1'b0;
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      TO_ERR    <= 1'b0;
    end else begin
      state     <= state_n;
      to_cnt    <= to_cnt_n;
      gap_cnt   <= gap_cnt_n;
      R_INC     <= r_inc_n;
      OUT_VALID <= out_valid_n;
      OUT_DATA  <= out_data_n;
      TO_ERR    <= to_err_n;
    end
  end

`ifdef RD_CTRL_XFER_CNT_EN
  // Completed-pop counter, wraps naturally at 16 bits
  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      XFER_CNT <= 16'h0000;
    end else if (state == POP) begin
      XFER_CNT <= XFER_CNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: cycle-timeline reference model plus directed scenarios.
module tb_fifo_rd_ctrl;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned GAP     = 2;
  localparam int unsigned TIMEOUT = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             rempty = 1'b1;
  logic             cons_busy = 1'b0;
  logic [WIDTH-1:0] rd_data = '0;
  logic             r_inc, out_valid, to_err;
  logic [WIDTH-1:0] out_data;
`ifdef RD_CTRL_XFER_CNT_EN
  logic [15:0]      xfer_cnt;
  logic [15:0]      xfer_model = 16'h0000;
`endif

  always #5 clk = ~clk;

  fifo_rd_ctrl #(.WIDTH(WIDTH), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .R_CLK(clk), .R_RST(rst_n), .EN(en), .REMPTY(rempty), .RD_DATA(rd_data),
    .CONS_BUSY(cons_busy), .R_INC(r_inc), .OUT_DATA(out_data), .OUT_VALID(out_valid),
    .TO_ERR(to_err)
`ifdef RD_CTRL_XFER_CNT_EN
    , .XFER_CNT(xfer_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // FIFO contents and consumer script
  logic [WIDTH-1:0] fifo_q[$];
  int cons_len   = 0;
  int busy_left  = 0;
  bit start_next = 0;

  // Reference timeline: cycle numbers of pop, first busy, and next idle window
  int cyc = 0;
  bit in_xfer = 0;
  int pop_cyc = 0;
  int busy_seen = -1;
  int idle_from = 0;
  logic exp_rinc = 0, exp_valid = 0, exp_toerr = 0;
  logic [WIDTH-1:0] exp_data = '0;
  logic [WIDTH-1:0] popped[$];
  int pop_cycles[$];
  int to_rise = -1;
  logic to_err_q = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_xfer   = 0;
      idle_from = 0;
      exp_rinc  = 0;
      exp_valid = 0;
      exp_data  = '0;
      exp_toerr = 0;
`ifdef RD_CTRL_XFER_CNT_EN
      xfer_model = 16'h0000;
`endif
    end else begin
      int c;
      c = cyc;
      if (r_inc) begin
        popped.push_back(out_data);
        pop_cycles.push_back(c);
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
`ifdef RD_CTRL_XFER_CNT_EN
        xfer_model = xfer_model + 16'd1;
`endif
      end
      exp_rinc  = 0;
      exp_valid = 0;
      if (!in_xfer) begin
        if (c >= idle_from) begin
          if (!en) exp_toerr = 0;
          else if (!rempty && !cons_busy) begin
            exp_rinc  = 1;
            exp_valid = 1;
            exp_data  = rd_data;
            in_xfer   = 1;
            pop_cyc   = c + 1;
            busy_seen = -1;
          end
        end
      end else if (c > pop_cyc) begin
        if (busy_seen < 0) begin
          if (cons_busy) busy_seen = c;
          else if (c == pop_cyc + int'(TIMEOUT)) begin
            exp_toerr = 1;
            in_xfer   = 0;
            idle_from = c + 1 + int'(GAP);
          end
        end else if (!cons_busy) begin
          in_xfer   = 0;
          idle_from = c + 1 + int'(GAP);
        end
      end
      cyc++;
    end
  end

  // Per-cycle comparison against the reference
  always @(negedge clk) begin
    check("r_inc", 32'(r_inc), 32'(exp_rinc));
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    check("out_data", 32'(out_data), 32'(exp_data));
    check("to_err", 32'(to_err), 32'(exp_toerr));
`ifdef RD_CTRL_XFER_CNT_EN
    check("xfer_cnt", 32'(xfer_cnt), 32'(xfer_model));
`endif
    if (to_err && !to_err_q) to_rise = cyc;
    to_err_q = to_err;
  end

  task automatic tick();
    @(negedge clk);
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) cons_busy = 1'b0;
    end
    if (start_next) begin
      cons_busy  = 1'b1;
      busy_left  = cons_len;
      start_next = 0;
    end
    if (out_valid && cons_len > 0) start_next = 1;
    rempty  = (fifo_q.size() == 0);
    rd_data = rempty ? '0 : fifo_q[0];
  endtask

  task automatic wait_pops(input int n, input int budget);
    int k;
    k = 0;
    while (popped.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (popped.size() < n) begin
      checks++;
      errors++;
      $display("FAIL wait_pop pops=%0d required=%0d", popped.size(), n);
    end
  endtask

  task automatic clear_log();
    popped.delete();
    pop_cycles.delete();
    to_rise = -1;
  endtask

  initial begin
    int t0;
    repeat (3) tick();
    check("rst_r_inc", 32'(r_inc), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data", 32'(out_data), 32'h0);
    check("rst_to_err", 32'(to_err), 32'h0);
    rst_n = 1'b1;
    tick();

    // Single word, busy for 3 cycles
    cons_len = 3;
    fifo_q.push_back(8'hA5);
    en = 1'b1;
    tick();
    t0 = cyc;
    repeat (20) tick();
    check("single_pops", 32'(popped.size()), 32'd1);
    if (popped.size() >= 1) begin
      check("single_data", 32'(popped[0]), 32'hA5);
      check("single_latency", 32'(pop_cycles[0] - t0), 32'd1);
    end

    // Burst of three, busy 4 cycles per word
    clear_log();
    cons_len = 4;
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    fifo_q.push_back(8'h33);
    repeat (40) tick();
    check("burst_pops", 32'(popped.size()), 32'd3);
    if (popped.size() >= 3) begin
      check("burst_d0", 32'(popped[0]), 32'h11);
      check("burst_d1", 32'(popped[1]), 32'h22);
      check("burst_d2", 32'(popped[2]), 32'h33);
      check("burst_space01", 32'(pop_cycles[1] - pop_cycles[0]), 32'd9);
      check("burst_space12", 32'(pop_cycles[2] - pop_cycles[1]), 32'd9);
    end

    // Timeout: consumer never acknowledges
    clear_log();
    cons_len = 0;
    fifo_q.push_back(8'h5A);
    fifo_q.push_back(8'hC3);
    repeat (30) tick();
    check("to_pops", 32'(popped.size()), 32'd2);
    if (popped.size() >= 2) begin
      check("to_rise_delay", 32'(to_rise - pop_cycles[0]), 32'd5);
      check("to_second_pop", 32'(pop_cycles[1] - pop_cycles[0]), 32'd8);
      check("to_d1", 32'(popped[1]), 32'hC3);
    end
    check("to_sticky", 32'(to_err), 32'h1);
    en = 1'b0;
    tick();
    check("to_cleared", 32'(to_err), 32'h0);
    repeat (3) tick();

    // Enable drop during WAIT_DONE
    clear_log();
    cons_len = 4;
    en = 1'b1;
    fifo_q.push_back(8'h77);
    fifo_q.push_back(8'h88);
    wait_pops(1, 20);
    tick();
    en = 1'b0;
    repeat (20) tick();
    check("endrop_pops", 32'(popped.size()), 32'd1);
    en = 1'b1;
    tick();
    check("reen_r_inc", 32'(r_inc), 32'h1);
    check("reen_data", 32'(out_data), 32'h88);
    repeat (15) tick();

    // Reset in the middle of a transfer
    clear_log();
    cons_len = 0;
    fifo_q.push_back(8'h99);
    wait_pops(1, 20);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_r_inc", 32'(r_inc), 32'h0);
    check("midrst_valid", 32'(out_valid), 32'h0);
    check("midrst_data", 32'(out_data), 32'h0);
    check("midrst_to_err", 32'(to_err), 32'h0);
    tick();
    rst_n = 1'b1;
    fifo_q.push_back(8'hAB);
    repeat (15) tick();
    check("postrst_pops", 32'(popped.size()), 32'd2);
    if (popped.size() >= 2) check("postrst_data", 32'(popped[1]), 32'hAB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
